// File: rtl/tone_write_sequencer_if.sv
// Host request handshake plus the shared tone-generator nibble bus for tone_write_sequencer.
interface tone_write_sequencer_if #(
  parameter int unsigned CHANNELS = 3
);
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_ch;
  logic [11:0]         req_freq;
  logic [2:0]          req_mask;
  logic [3:0]          dout;
  logic [CHANNELS-1:0] lsel;
  logic [CHANNELS-1:0] hsel;
  logic [CHANNELS-1:0] hhsel;
  logic                busy;
  logic                err;

  modport master (
    output req_valid, req_ch, req_freq, req_mask,
    input  req_ready, dout, lsel, hsel, hhsel, busy, err
  );

  modport slave (
    input  req_valid, req_ch, req_freq, req_mask,
    output req_ready, dout, lsel, hsel, hhsel, busy, err
  );
endinterface

// File: rtl/tone_write_sequencer.sv
// Buffers 12-bit tone frequency updates and serialises them into strobed nibble writes
// on a shared 4-bit bus, one SETUP/STROBE/HOLD write at a time.
module tone_write_sequencer #(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tone_write_sequencer_if.slave bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [1:0]  ch;
    logic [11:0] freq;
    logic [2:0]  mask;
  } req_t;

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  req_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            full, empty, push, pop, take_head, head_ch_ok;
  req_t            head;

  state_e          state_q, state_d;
  req_t            work_q, work_d;
  logic [1:0]      nib_q, nib_d, next_nib;
  logic            next_ok;
  logic [3:0]      dout_q, dout_d;
  logic            err_q, err_d;
  logic [CHANNELS-1:0] lsel, hsel, hhsel;

  function automatic logic [3:0] nibble(input logic [11:0] f, input logic [1:0] n);
    case (n)
      2'd0:    return f[3:0];
      2'd1:    return f[7:4];
      default: return f[11:8];
    endcase
  endfunction

  function automatic logic [1:0] first_nib(input logic [2:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    return 2'd2;
  endfunction

  assign full       = (count_q == (PtrW+1)'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign push       = bus.req_valid & ~full;
  assign head       = mem_q[rd_ptr_q];
  assign head_ch_ok = (32'(head.ch) < CHANNELS);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{ch: bus.req_ch, freq: bus.req_freq, mask: bus.req_mask};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // Next enabled nibble of the current request, if any remain after nib_q.
  always_comb begin
    next_ok  = 1'b0;
    next_nib = nib_q;
    if (nib_q == 2'd0 && work_q.mask[1]) begin
      next_ok  = 1'b1;
      next_nib = 2'd1;
    end else if (nib_q != 2'd2 && work_q.mask[2]) begin
      next_ok  = 1'b1;
      next_nib = 2'd2;
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    nib_d     = nib_q;
    dout_d    = dout_q;
    err_d     = 1'b0;
    pop       = 1'b0;
    take_head = 1'b0;
    unique case (state_q)
      StIdle:   take_head = 1'b1;
      StSetup:  state_d = StStrobe;
      StStrobe: state_d = StHold;
      StHold: begin
        if (next_ok) begin
          nib_d   = next_nib;
          dout_d  = nibble(work_q.freq, next_nib);
          state_d = StSetup;
        end else begin
          take_head = 1'b1;
        end
      end
      default:  state_d = StIdle;
    endcase
    // Popping straight into SETUP keeps back-to-back requests gap-free.
    if (take_head) begin
      state_d = StIdle;
      if (!empty) begin
        pop = 1'b1;
        if (!head_ch_ok) begin
          err_d = 1'b1;
        end else if (head.mask != '0) begin
          work_d  = head;
          nib_d   = first_nib(head.mask);
          dout_d  = nibble(head.freq, first_nib(head.mask));
          state_d = StSetup;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      nib_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      nib_q   <= nib_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode from registered state so reset drops them asynchronously.
  always_comb begin
    lsel  = '0;
    hsel  = '0;
    hhsel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (state_q == StStrobe && work_q.ch == 2'(i)) begin
        lsel[i]  = (nib_q == 2'd0);
        hsel[i]  = (nib_q == 2'd1);
        hhsel[i] = (nib_q == 2'd2);
      end
    end
  end

  assign bus.req_ready = ~full;
  assign bus.dout      = dout_q;
  assign bus.lsel      = lsel;
  assign bus.hsel      = hsel;
  assign bus.hhsel     = hhsel;
  assign bus.busy      = (state_q != StIdle) | ~empty;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_tone_write_sequencer.sv
// Self-checking bench: table-driven requests, a strobe scoreboard and hand-written timing cases.
module tb_tone_write_sequencer;
  localparam int unsigned CH    = 3;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tone_write_sequencer_if #(.CHANNELS(CH)) bus ();

  tone_write_sequencer #(
    .CHANNELS  (CH),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]  ch;
    logic [11:0] freq;
    logic [2:0]  mask;
    int          exp_err;
    int          exp_strobes;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         n_strobes = 0;
  int         err_cycles = 0;
  int         err_run = 0;
  int         err_max_run = 0;
  int         busy_fall_cyc = 0;
  logic       busy_prev = 1'b0;
  logic       saw_stall = 1'b0;
  logic [7:0] exp_q[$];
  int         strobe_cyc[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Event encoding: {class(0=L,1=H,2=HH), channel, nibble}.
  task automatic model_push(input logic [1:0] ch, input logic [11:0] freq, input logic [2:0] mask);
    logic [11:0] f;
    f = freq;
    if (32'(ch) >= CH) return;
    for (int n = 0; n < 3; n++) begin
      if (mask[n]) exp_q.push_back({2'(n), ch, f[4*n +: 4]});
    end
  endtask

  task automatic tick();
    logic [3*CH-1:0] all;
    int              ones;
    logic [7:0]      ev;
    @(posedge clk);
    #1;
    cyc++;
    all  = {bus.hhsel, bus.hsel, bus.lsel};
    ones = $countones(all);
    if (ones != 0) begin
      check("sel_onehot", ones, 1);
      ev = 8'h0;
      for (int i = 0; i < CH; i++) begin
        if (bus.lsel[i])  ev = {2'd0, 2'(i), bus.dout};
        if (bus.hsel[i])  ev = {2'd1, 2'(i), bus.dout};
        if (bus.hhsel[i]) ev = {2'd2, 2'(i), bus.dout};
      end
      n_strobes++;
      strobe_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got event 0x%0h, expected none", ev);
      end else begin
        check("strobe_event", int'(ev), int'(exp_q.pop_front()));
      end
    end
    if (bus.err) begin
      err_cycles++;
      err_run++;
      if (err_run > err_max_run) err_max_run = err_run;
    end else begin
      err_run = 0;
    end
    if (busy_prev && !bus.busy) busy_fall_cyc = cyc;
    busy_prev = bus.busy;
  endtask

  // Holds valid until accepted; leaves valid high so the caller may chain pushes.
  task automatic push(input logic [1:0] ch, input logic [11:0] freq, input logic [2:0] mask,
                      output int acc_cyc);
    logic acc;
    int   waited;
    bus.req_valid = 1'b1;
    bus.req_ch    = ch;
    bus.req_freq  = freq;
    bus.req_mask  = mask;
    waited        = 0;
    acc_cyc       = -1;
    do begin
      acc = bus.req_ready;
      if (!acc) saw_stall = 1'b1;
      tick();
      waited++;
    end while (!acc && waited < 100);
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout: got ready=0 for %0d cycles, expected acceptance", waited);
    end else begin
      model_push(ch, freq, mask);
      acc_cyc = cyc;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.busy && n < 300) begin
      tick();
      n++;
    end
    check({name, "_idle"}, int'(bus.busy), 0);
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, int'(bus.req_ready), 1);
    check({name, "_busy"}, int'(bus.busy), 0);
    check({name, "_err"}, int'(bus.err), 0);
    check({name, "_dout"}, int'(bus.dout), 0);
    check({name, "_sel"}, int'({bus.hhsel, bus.hsel, bus.lsel}), 0);
  endtask

  initial begin
    vec_t tbl[7];
    int   acc, acc2, base_s, base_e, n;

    tbl[0] = '{2'd1, 12'hA5C, 3'b111, 0, 3};
    tbl[1] = '{2'd0, 12'h321, 3'b101, 0, 2};
    tbl[2] = '{2'd2, 12'hFFF, 3'b010, 0, 1};
    tbl[3] = '{2'd3, 12'h123, 3'b111, 1, 0};
    tbl[4] = '{2'd2, 12'h0F0, 3'b000, 0, 0};
    tbl[5] = '{2'd0, 12'h8B4, 3'b100, 0, 1};
    tbl[6] = '{2'd1, 12'h777, 3'b011, 0, 2};

    bus.req_valid = 1'b0;
    bus.req_ch    = '0;
    bus.req_freq  = '0;
    bus.req_mask  = '0;

    repeat (3) tick();
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("after_release");

    // Table-driven: each request in isolation.
    for (int i = 0; i < 7; i++) begin
      base_s = n_strobes;
      base_e = err_cycles;
      push(tbl[i].ch, tbl[i].freq, tbl[i].mask, acc);
      wait_idle("tbl");
      check("tbl_err_cycles", err_cycles - base_e, tbl[i].exp_err);
      check("tbl_strobes", n_strobes - base_s, tbl[i].exp_strobes);
    end

    // Single full-mask request: latency, spacing and BUSY fall.
    strobe_cyc.delete();
    push(2'd1, 12'hA5C, 3'b111, acc);
    wait_idle("full");
    check("full_strobe_count", strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3) begin
      check("full_first_latency", strobe_cyc[0] - acc, 2);
      check("full_spacing1", strobe_cyc[1] - strobe_cyc[0], 3);
      check("full_spacing2", strobe_cyc[2] - strobe_cyc[1], 3);
      check("full_busy_fall", busy_fall_cyc - strobe_cyc[2], 2);
    end

    // Back-to-back requests with no idle gap.
    strobe_cyc.delete();
    push(2'd0, 12'h321, 3'b101, acc);
    push(2'd2, 12'hFFF, 3'b010, acc2);
    wait_idle("b2b");
    check("b2b_strobe_count", strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3) begin
      check("b2b_first_latency", strobe_cyc[0] - acc, 2);
      check("b2b_gap1", strobe_cyc[1] - strobe_cyc[0], 3);
      check("b2b_gap2", strobe_cyc[2] - strobe_cyc[0], 6);
    end

    // Six pushes with valid held: FIFO fills, ready drops, order preserved.
    saw_stall = 1'b0;
    base_s    = n_strobes;
    n         = 0;
    for (int i = 0; i < 6; i++) begin
      push(2'(i % 3), 12'h100 * 12'(i) + 12'h0A1 + 12'(i), 3'b111, acc);
      if (acc >= 0) n++;
    end
    wait_idle("fill");
    check("fill_accepted", n, 6);
    check("fill_ready_dropped", int'(saw_stall), 1);
    check("fill_ready_back", int'(bus.req_ready), 1);
    check("fill_strobes", n_strobes - base_s, 18);

    // Bad channel followed by a valid request.
    base_s      = n_strobes;
    base_e      = err_cycles;
    err_max_run = 0;
    push(2'd3, 12'h123, 3'b111, acc);
    push(2'd0, 12'h456, 3'b011, acc2);
    wait_idle("badch");
    check("badch_err_cycles", err_cycles - base_e, 1);
    check("badch_err_width", err_max_run, 1);
    check("badch_strobes", n_strobes - base_s, 2);

    // Empty mask: silent discard, BUSY back low within 2 cycles.
    base_s = n_strobes;
    base_e = err_cycles;
    push(2'd2, 12'hABC, 3'b000, acc);
    bus.req_valid = 1'b0;
    tick();
    tick();
    check("mask0_busy", int'(bus.busy), 0);
    repeat (3) tick();
    check("mask0_err", err_cycles - base_e, 0);
    check("mask0_strobes", n_strobes - base_s, 0);

    // Reset during STROBE with two requests still queued.
    base_s = n_strobes;
    push(2'd0, 12'h111, 3'b111, acc);
    push(2'd1, 12'h222, 3'b111, acc);
    push(2'd2, 12'h333, 3'b111, acc);
    bus.req_valid = 1'b0;
    n = 0;
    while (n_strobes == base_s && n < 20) begin
      tick();
      n++;
    end
    check("rst_strobe_seen", n_strobes - base_s, 1);
    check("rst_sel_before", $countones({bus.hhsel, bus.hsel, bus.lsel}), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_sel_async_drop", int'({bus.hhsel, bus.hsel, bus.lsel}), 0);
    exp_q.delete();
    tick();
    tick();
    rst_n  = 1'b1;
    base_s = n_strobes;
    repeat (20) tick();
    check("rst_ready", int'(bus.req_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_no_strobes", n_strobes - base_s, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tone_write_sequencer.md
Name: tone_write_sequencer

Overview:
- Host-side write scheduler for a bank of tone generator channels.
- Accepts 12-bit frequency updates over a valid/ready interface and buffers them in a small FIFO.
- Serialises each update into up to three nibble writes on the tone generators' shared 4-bit DIN bus, using per-channel LSEL/HSEL/HHSEL strobes.
- Only one nibble write is in flight at any time, so the shared DIN bus is never contended.

Parameters:
- CHANNELS, 3: number of tone generator channels driven (1..4).
- FIFO_DEPTH, 4: request FIFO entries; power of two, at least 2.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  host request valid.
- REQ_READY  out  1  FIFO can accept; equals !full.
- REQ_CH  in  2  target channel index.
- REQ_FREQ  in  12  frequency word; [3:0] low, [7:4] high, [11:8] highest nibble.
- REQ_MASK  in  3  nibble enables; bit0 low, bit1 high, bit2 highest.
- DOUT  out  4  nibble bus to every channel's DIN.
- LSEL  out  CHANNELS  per-channel low-nibble strobe.
- HSEL  out  CHANNELS  per-channel high-nibble strobe.
- HHSEL  out  CHANNELS  per-channel highest-nibble strobe.
- BUSY  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- ERR  out  1  one-cycle pulse when a request with REQ_CH >= CHANNELS is discarded.

Behaviour:
- Reset (async assert, sync release) clears:
  - FIFO pointers and count to 0; REQ_READY=1.
  - DOUT=0; all SEL vectors=0; BUSY=0; ERR=0; FSM in IDLE.
- Reset mid-write: strobes drop immediately and all queued requests are lost.
- Push: when REQ_VALID & REQ_READY at a rising edge, {CH, FREQ, MASK} is written to the FIFO.
  - The host must hold its inputs stable while VALID=1 and READY=0.
- Simultaneous push and pop are allowed while not full; the count is unchanged.
- When full, REQ_READY=0 and pushes are ignored, even if a pop occurs in the same cycle.
- FSM states: IDLE, SETUP, STROBE, HOLD. Each nibble write takes 3 cycles:
  - SETUP: DOUT = selected nibble, all SEL low.
  - STROBE: DOUT held; exactly one SEL bit high, for the selected nibble class and channel.
  - HOLD: DOUT held; SEL low.
- Nibble order is low, then high, then highest. Nibbles whose mask bit is 0 are skipped, with no cycles spent on them.
- Pop decision: taken in IDLE, or in HOLD of the last enabled nibble.
  - If the FIFO is non-empty, pop the head into the working register.
  - If the head is valid (CH < CHANNELS, MASK != 0), next state is SETUP of its first enabled nibble, so back-to-back requests have no idle gap.
  - If the FIFO is empty, next state is IDLE.
- Invalid heads:
  - Head with CH >= CHANNELS: discarded, ERR pulses for one cycle, next state is IDLE.
  - Head with MASK == 0: discarded silently, next state is IDLE.
- Latency: a request accepted at edge t on an empty, idle block gives:
  - pop at edge t+1;
  - SETUP during cycle t+1..t+2;
  - strobe high during cycle t+2..t+3, i.e. 2 cycles after acceptance.
- Duration: a full-mask write occupies 9 cycles (SETUP..HOLD ×3).
- DOUT keeps its last value in IDLE.
- SEL vectors are never high in two bits at once.

Test Plan:
- Reset release, then one request CH=1, FREQ=0xA5C, MASK=111 ->
  - HSEL... sequence is LSEL[1] with DOUT=0xC, then HSEL[1] with DOUT=0x5, then HHSEL[1] with DOUT=0xA;
  - strobes spaced 3 cycles apart, first strobe 2 cycles after the accept edge;
  - BUSY falls after the final HOLD.
- Requests MASK=101 FREQ=0x321 CH=0, then MASK=010 FREQ=0xFFF CH=2, pushed back-to-back ->
  - LSEL[0]/0x1, then HHSEL[0]/0x3, then HSEL[2]/0xF;
  - no IDLE cycle between requests; 9 cycles from first SETUP to last HOLD.
- Push 6 requests with REQ_VALID held high and FIFO_DEPTH=4 ->
  - REQ_READY drops when 4 entries are held and reasserts as entries are popped;
  - all 6 writes emerge in order, none dropped or duplicated.
- Request CH=3 with CHANNELS=3, followed by a valid request ->
  - ERR is high for exactly 1 cycle;
  - no SEL activity for the bad request;
  - the valid request executes normally.
- Request MASK=000 -> no strobes, no ERR, BUSY returns to 0 within 2 cycles.
- Assert RST_N=0 during STROBE with 2 requests queued ->
  - SEL drops asynchronously;
  - after release, REQ_READY=1, BUSY=0, and no further strobes occur.
